// File: rtl/estimador_media.sv
// Block-statistics estimator: accumulates non-overlapping blocks of 2^LOG2N unsigned
// samples and reports the truncated mean, minimum and maximum of each block.
//
// state  | meaning
// ACUM   | accepting samples into the current block (IN_READY=1)
// SALIDA | block result presented, waiting for OUT_READY (OUT_VALID=1)
module estimador_media #(
   parameter int W     = 8,
   parameter int LOG2N = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   input  logic [W-1:0] IN_DATA,
   output logic         IN_READY,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [W-1:0] OUT_MEAN,
   output logic [W-1:0] OUT_MIN,
   output logic [W-1:0] OUT_MAX
);

   typedef enum logic {
      ACUM   = 1'b0,
      SALIDA = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [LOG2N-1:0]     r_cnt;
   logic [W+LOG2N-1:0]   r_acc;
   logic [W-1:0]         r_min;
   logic [W-1:0]         r_max;
   logic [W-1:0]         r_mean;
   logic [W-1:0]         r_out_min;
   logic [W-1:0]         r_out_max;

   logic                 w_accept;
   logic                 w_first;
   logic                 w_last;
   logic [W+LOG2N-1:0]   w_sample_ext;
   logic [W+LOG2N-1:0]   w_sum;
   logic [W-1:0]         w_min;
   logic [W-1:0]         w_max;

   assign w_accept     = (r_state == ACUM) && IN_VALID;
   assign w_first      = (r_cnt == '0);
   assign w_last       = &r_cnt;
   assign w_sample_ext = {{LOG2N{1'b0}}, IN_DATA};

   // The first sample of a block overrides whatever the running registers hold.
   assign w_sum = w_first ? w_sample_ext : (r_acc + w_sample_ext);
   assign w_min = (w_first || (IN_DATA < r_min)) ? IN_DATA : r_min;
   assign w_max = (w_first || (IN_DATA > r_max)) ? IN_DATA : r_max;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ACUM;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      case (r_state)
         ACUM: begin
            IN_READY = 1'b1;
            if (IN_VALID && w_last) begin
               w_next = SALIDA;
            end
         end
         SALIDA: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) begin
               w_next = ACUM;
            end
         end
         default: w_next = ACUM;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_min     <= '0;
         r_max     <= '0;
         r_mean    <= '0;
         r_out_min <= '0;
         r_out_max <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_sum;
         r_min <= w_min;
         r_max <= w_max;
         if (w_last) begin
            r_mean    <= w_sum[W+LOG2N-1:LOG2N];
            r_out_min <= w_min;
            r_out_max <= w_max;
         end
      end
   end

   assign OUT_MEAN = r_mean;
   assign OUT_MIN  = r_out_min;
   assign OUT_MAX  = r_out_max;

endmodule

// File: tb/tb_estimador_media.sv
// Randomised and directed bench for estimador_media: a block-level reference model
// queues expected results, and a negedge monitor checks handshakes and result values.
module tb_estimador_media;
   localparam int W     = 8;
   localparam int LOG2N = 3;
   localparam int N     = 1 << LOG2N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_mean;
   logic [W-1:0] out_min;
   logic [W-1:0] out_max;

   int vectors = 0;
   int miscompares = 0;
   bit mon_en = 1'b0;
   bit rand_rdy = 1'b0;

   typedef struct packed {
      logic [W-1:0] mean;
      logic [W-1:0] mn;
      logic [W-1:0] mx;
   } result_t;

   result_t q[$];
   int      blk[$];
   bit      exp_out = 1'b0;

   estimador_media #(.W(W), .LOG2N(LOG2N)) dut (
      .CLK(clk), .RST(rst),
      .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_MEAN(out_mean), .OUT_MIN(out_min), .OUT_MAX(out_max)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a block is a list of samples; its result is plain arithmetic over that list.
   always @(posedge clk) begin
      if (rst) begin
         blk.delete();
         q.delete();
         exp_out = 1'b0;
      end else if (!exp_out && in_valid) begin
         blk.push_back(int'(in_data));
         if (blk.size() == N) begin
            int s, mn, mx;
            result_t r;
            s = 0; mn = blk[0]; mx = blk[0];
            foreach (blk[i]) begin
               s += blk[i];
               if (blk[i] < mn) mn = blk[i];
               if (blk[i] > mx) mx = blk[i];
            end
            r.mean = W'(s / N);
            r.mn   = W'(mn);
            r.mx   = W'(mx);
            q.push_back(r);
            blk.delete();
            exp_out = 1'b1;
         end
      end else if (exp_out && out_ready) begin
         exp_out = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("in_ready", int'(in_ready), int'(!exp_out));
         chk("out_valid", int'(out_valid), int'(exp_out));
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               chk("mean", int'(out_mean), int'(q[0].mean));
               chk("min", int'(out_min), int'(q[0].mn));
               chk("max", int'(out_max), int'(q[0].mx));
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int d, input int gap);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data  = W'(d);
      n = 0;
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin
      int ramp[8];
      int bp[8];
      ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
      bp   = '{5, 200, 3, 9, 9, 9, 9, 100};

      repeat (2) tick();
      mon_en = 1'b1;
      rst = 1'b0;
      chk("rst_mean", int'(out_mean), 0);
      chk("rst_min", int'(out_min), 0);
      chk("rst_max", int'(out_max), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);

      for (int i = 0; i < N; i++) send(10, 0);
      repeat (2) tick();
      for (int i = 0; i < N; i++) send(ramp[i], 0);
      repeat (2) tick();
      for (int i = 0; i < N; i++) send(255, 0);
      repeat (2) tick();

      // Backpressure: result stalls 5 cycles while 77 waits at the input.
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) send(bp[i], 0);
      in_valid = 1'b1;
      in_data  = 8'd77;
      repeat (4) tick();
      chk("stall_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      send(77, 0);
      for (int i = 1; i < N; i++) send(i * 3, 0);
      repeat (2) tick();

      // Reset in the middle of a block discards the partial sums.
      for (int i = 0; i < 4; i++) send(50, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_in_ready", int'(in_ready), 1);
      for (int i = 0; i < N; i++) send(20, 0);
      repeat (2) tick();

      for (int i = 1; i <= N; i++) send(i, 2);
      repeat (2) tick();

      rand_rdy = 1'b1;
      for (int b = 0; b < 30; b++) begin
         for (int i = 0; i < N; i++) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("queue_drained", q.size(), 0);
      chk("final_in_ready", int'(in_ready), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
